// File: rtl/player_controller.sv
// Per-player fighter FSM: buttons and opponent hits in, state/health/position out, one cycle per frame.
// Optional invulnerability window after hitstun is enabled by defining PLAYER_INVULN_EN.
module player_controller #(
  parameter logic [2:0] MAX_HEALTH = 3'd5,
  parameter logic [8:0] START_POS  = 9'd64,
  parameter logic [8:0] POS_MIN    = 9'd0,
  parameter logic [8:0] POS_MAX    = 9'd319,
  parameter logic [8:0] SPEED      = 9'd2,
  parameter int         WINDUP     = 4,
  parameter int         ACTIVE     = 3,
  parameter int         RECOVERY   = 6,
  parameter int         HITSTUN    = 10,
  parameter int         IFRAMES    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       btn_block,
  input  logic       opp_hit,
  output logic [3:0] player_state,
  output logic [2:0] player_health,
  output logic [8:0] player_pos,
  output logic       attack_active,
  output logic       invuln
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEFT    = 4'd1,
    ST_RIGHT   = 4'd2,
    ST_WINDUP  = 4'd3,
    ST_ATTACK  = 4'd4,
    ST_RECOVER = 4'd5,
    ST_BLOCK   = 4'd6,
    ST_HITSTUN = 4'd7,
    ST_DEAD    = 4'd8
  } state_t;

  localparam logic [2:0] GS_IDLE      = 3'd0;
  localparam logic [2:0] GS_COUNTDOWN = 3'd1;
  localparam logic [2:0] GS_FIGHT     = 3'd2;

  localparam logic [3:0] WINDUP_LD  = 4'(WINDUP - 1);
  localparam logic [3:0] ACTIVE_LD  = 4'(ACTIVE - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVERY - 1);
  localparam logic [3:0] HITSTUN_LD = 4'(HITSTUN - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] health_q, health_d;
  logic [8:0] pos_q, pos_d;
  logic       att_q, att_d;
  logic       inv_active;
  logic       hit_ok;

  // Movement is computed one bit wider so neither limit can wrap.
  logic [9:0] pos_ext, speed_ext, min_ext, max_ext, pos_sum;
  logic [8:0] pos_left, pos_right;

  assign pos_ext   = {1'b0, pos_q};
  assign speed_ext = {1'b0, SPEED};
  assign min_ext   = {1'b0, POS_MIN};
  assign max_ext   = {1'b0, POS_MAX};
  assign pos_sum   = pos_ext + speed_ext;

  always_comb begin
    pos_left  = POS_MIN;
    pos_right = POS_MAX;
    if (pos_ext >= min_ext + speed_ext) begin
      pos_left = pos_q - SPEED;
    end
    if (pos_sum <= max_ext) begin
      pos_right = pos_sum[8:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      health_q <= MAX_HEALTH;
      pos_q    <= START_POS;
      att_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      health_q <= health_d;
      pos_q    <= pos_d;
      att_q    <= att_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    health_d = health_q;
    pos_d    = pos_q;
    att_d    = 1'b0;
    hit_ok   = 1'b0;
    case (game_state)
      GS_IDLE, GS_COUNTDOWN: begin
        state_d  = ST_IDLE;
        cnt_d    = 4'd0;
        health_d = MAX_HEALTH;
        pos_d    = START_POS;
      end
      GS_FIGHT: begin
        hit_ok = opp_hit && (state_q != ST_DEAD) && (state_q != ST_HITSTUN) && !inv_active;
        if (hit_ok) begin
          if (state_q == ST_BLOCK) begin
            state_d = ST_BLOCK;
          end else begin
            health_d = (health_q == 3'd0) ? 3'd0 : health_q - 3'd1;
            if (health_d == 3'd0) begin
              state_d = ST_DEAD;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_HITSTUN;
              cnt_d   = HITSTUN_LD;
            end
          end
        end else begin
          if (state_q == ST_LEFT) begin
            pos_d = pos_left;
          end else if (state_q == ST_RIGHT) begin
            pos_d = pos_right;
          end
          case (state_q)
            ST_IDLE, ST_LEFT, ST_RIGHT: begin
              if (btn_attack) begin
                state_d = ST_WINDUP;
                cnt_d   = WINDUP_LD;
              end else if (btn_block) begin
                state_d = ST_BLOCK;
              end else if (btn_left && !btn_right) begin
                state_d = ST_LEFT;
              end else if (btn_right && !btn_left) begin
                state_d = ST_RIGHT;
              end else begin
                state_d = ST_IDLE;
              end
            end
            ST_WINDUP: begin
              if (cnt_q == 4'd0) begin
                state_d = ST_ATTACK;
                cnt_d   = ACTIVE_LD;
              end else begin
                cnt_d = cnt_q - 4'd1;
              end
            end
            ST_ATTACK: begin
              if (cnt_q == 4'd0) begin
                state_d = ST_RECOVER;
                cnt_d   = RECOVER_LD;
              end else begin
                cnt_d = cnt_q - 4'd1;
              end
            end
            ST_RECOVER, ST_HITSTUN: begin
              if (cnt_q == 4'd0) begin
                state_d = ST_IDLE;
              end else begin
                cnt_d = cnt_q - 4'd1;
              end
            end
            ST_BLOCK: begin
              state_d = btn_block ? ST_BLOCK : ST_IDLE;
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end
        att_d = (state_d == ST_ATTACK);
      end
      default: begin
        att_d = 1'b0;
      end
    endcase
  end

`ifdef PLAYER_INVULN_EN
  localparam logic [4:0] IFRAMES_LD = 5'(IFRAMES - 1);

  logic       inv_q, inv_d;
  logic [4:0] icnt_q, icnt_d;
  logic       hitstun_exit;

  // Hits are ignored in HITSTUN, so a zero count there always means a timed exit.
  assign hitstun_exit = (game_state == GS_FIGHT) && (state_q == ST_HITSTUN) && (cnt_q == 4'd0);

  always_comb begin
    inv_d  = inv_q;
    icnt_d = icnt_q;
    if (game_state == GS_IDLE || game_state == GS_COUNTDOWN) begin
      inv_d  = 1'b0;
      icnt_d = 5'd0;
    end else if (game_state == GS_FIGHT) begin
      if (hitstun_exit) begin
        inv_d  = 1'b1;
        icnt_d = IFRAMES_LD;
      end else if (inv_q) begin
        if (icnt_q == 5'd0) begin
          inv_d = 1'b0;
        end else begin
          icnt_d = icnt_q - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inv_q  <= 1'b0;
      icnt_q <= 5'd0;
    end else begin
      inv_q  <= inv_d;
      icnt_q <= icnt_d;
    end
  end

  assign inv_active = inv_q;
`else
  assign inv_active = 1'b0;
`endif

  assign player_state  = state_q;
  assign player_health = health_q;
  assign player_pos    = pos_q;
  assign attack_active = att_q;
  assign invuln        = inv_active;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: stimulus pushes model predictions, a monitor pops and compares.
module tb_player_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] game_state = 3'd0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0, btn_block = 1'b0;
  logic       opp_hit = 1'b0;
  logic [3:0] player_state;
  logic [2:0] player_health;
  logic [8:0] player_pos;
  logic       attack_active;
  logic       invuln;

  player_controller dut (
    .clk           (clk),
    .reset         (reset),
    .game_state    (game_state),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_attack    (btn_attack),
    .btn_block     (btn_block),
    .opp_hit       (opp_hit),
    .player_state  (player_state),
    .player_health (player_health),
    .player_pos    (player_pos),
    .attack_active (attack_active),
    .invuln        (invuln)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int hp;
    int pos;
    int att;
    int inv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: durations expressed as frames spent in a state, window as frames remaining.
  int m_state = 0, m_hp = 5, m_pos = 64, m_att = 0, m_spent = 0, m_inv_left = 0;

  function automatic int dur(input int s);
    case (s)
      3: return 4;
      4: return 3;
      5: return 6;
      7: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(input bit rst, input int gs, input bit l, input bit r,
                                     input bit a, input bit b, input bit h);
    int  cur;
    bit  hit_ok;
    bit  left_hitstun;
    cur = m_state;
    left_hitstun = 1'b0;
    if (rst || gs <= 1) begin
      m_state = 0; m_hp = 5; m_pos = 64; m_att = 0; m_spent = 0; m_inv_left = 0;
      return;
    end
    if (gs != 2) begin
      m_att = 0;
      return;
    end
    hit_ok = h && cur != 8 && cur != 7 && m_inv_left == 0;
    if (hit_ok) begin
      if (cur != 6) begin
        m_hp = (m_hp > 0) ? m_hp - 1 : 0;
        if (m_hp == 0) m_state = 8;
        else begin m_state = 7; m_spent = 1; end
      end
    end else begin
      if (cur == 1) m_pos = (m_pos - 2 < 0) ? 0 : m_pos - 2;
      if (cur == 2) m_pos = (m_pos + 2 > 319) ? 319 : m_pos + 2;
      case (cur)
        0, 1, 2: begin
          if (a) begin m_state = 3; m_spent = 1; end
          else if (b) m_state = 6;
          else if (l && !r) m_state = 1;
          else if (r && !l) m_state = 2;
          else m_state = 0;
        end
        3, 4, 5, 7: begin
          if (m_spent >= dur(cur)) begin
            m_state = (cur == 3) ? 4 : (cur == 4) ? 5 : 0;
            m_spent = 1;
            left_hitstun = (cur == 7);
          end else begin
            m_spent++;
          end
        end
        6: m_state = b ? 6 : 0;
        default: ;
      endcase
    end
`ifdef PLAYER_INVULN_EN
    if (left_hitstun) m_inv_left = 30;
    else if (m_inv_left > 0) m_inv_left--;
`endif
    m_att = (m_state == 4) ? 1 : 0;
  endfunction

  task automatic drive(input bit rst, input int gs, input bit l, input bit r,
                       input bit a, input bit b, input bit h);
    exp_t e;
    @(negedge clk);
    reset = rst; game_state = 3'(gs);
    btn_left = l; btn_right = r; btn_attack = a; btn_block = b; opp_hit = h;
    model_step(rst, gs, l, r, a, b, h);
    e.st = m_state; e.hp = m_hp; e.pos = m_pos; e.att = m_att; e.inv = (m_inv_left > 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic idle(input int gs, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, gs, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string nm, input logic [8:0] got, input int want);
    checks++;
    if (got !== 9'(want)) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state", 9'(player_state), e.st);
        check("health", 9'(player_health), e.hp);
        check("pos", player_pos, e.pos);
        check("attack_active", 9'(attack_active), e.att);
        check("invuln", 9'(invuln), e.inv);
      end
    end
  end

  initial begin : stim
    int gs;
    int budget;
    drive(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1, 3);
    // attack chain
    drive(1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 16);
    // walk into the left wall, then both directions
    for (int i = 0; i < 36; i++) drive(1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // walk into the right wall
    for (int i = 0; i < 165; i++) drive(1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // blocked hit, then a real hit
    for (int i = 0; i < 3; i++) drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 2);
    drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 12);
    // knock out with spaced hits (wider than any invulnerability window), freeze, restart
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 45);
    end
    drive(1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 3);
    idle(1, 2);
    // hit five frames after hitstun ends
    idle(2, 1);
    drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 14);
    drive(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 40);
    // mid-attack reset
    drive(1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 5);
    drive(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // randomized play
    gs = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 2) gs = ($urandom_range(99) < 60) ? 2 : int'($urandom_range(5));
      drive($urandom_range(999) < 4, gs,
            $urandom_range(99) < 40, $urandom_range(99) < 40,
            $urandom_range(99) < 8, $urandom_range(99) < 20,
            $urandom_range(99) < 10);
    end
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
